// File: rtl/mem_wb_stage.sv
// MEM stage with byte-lane data RAM, right-justified loads and the MEM/WB pipeline register.
// Misaligned accesses are suppressed and reported one cycle later on o_misaligned.
module mem_wb_stage #(
    parameter  int unsigned NBITS     = 32,
    parameter  int unsigned REGS      = 5,
    parameter  int unsigned RAM_WORDS = 256,
    localparam int unsigned AW        = $clog2(RAM_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [NBITS-1:0]  i_MEM_ALU,
    input  logic [NBITS-1:0]  i_MEM_StoreData,
    input  logic              i_MEM_MemRead,
    input  logic              i_MEM_MemWrite,
    input  logic [1:0]        i_MEM_Size,
    input  logic              i_MEM_ZeroExtend,
    input  logic              i_MEM_MemToReg,
    input  logic              i_MEM_LUI,
    input  logic              i_MEM_JAL,
    input  logic              i_MEM_RegWrite,
    input  logic [NBITS-1:0]  i_MEM_Extend,
    input  logic [NBITS-1:0]  i_MEM_PC8,
    input  logic [REGS-1:0]   i_MEM_Rd,
    output logic [NBITS-1:0]  o_WB_DataMemory,
    output logic [NBITS-1:0]  o_WB_ALU,
    output logic [NBITS-1:0]  o_WB_Extend,
    output logic [NBITS-1:0]  o_WB_PC8,
    output logic [1:0]        o_WB_SizeFiltroL,
    output logic              o_WB_ZeroExtend,
    output logic              o_WB_MemToReg,
    output logic              o_WB_LUI,
    output logic              o_WB_JAL,
    output logic              o_WB_RegWrite,
    output logic [REGS-1:0]   o_WB_Rd,
    output logic              o_misaligned,
    input  logic [AW-1:0]     i_dbg_addr,
    output logic [NBITS-1:0]  o_dbg_data
);

    localparam int unsigned LANES = NBITS / 8;
    localparam logic [LANES-1:0] HALF_LO = LANES'(2'b11);

    logic [NBITS-1:0] mem [RAM_WORDS];

    logic [AW-1:0]    word_idx;
    logic [1:0]       lane;
    logic             access;
    logic             misaligned;
    logic             store_en;
    logic [LANES-1:0] we;
    logic [NBITS-1:0] wdata;

    logic [NBITS-1:0] rd_word;
    logic [1:0]       lane_q;
    logic             load_valid;

    assign word_idx = i_MEM_ALU[AW+1:2];
    assign lane     = i_MEM_ALU[1:0];

    always_comb begin
        access     = i_MEM_MemRead | i_MEM_MemWrite;
        misaligned = access & (((i_MEM_Size == 2'b01) & lane[0]) |
                               (i_MEM_Size[1] & (lane != 2'b00)));
        // reset low also blocks the write so a store coinciding with reset is dropped
        store_en   = i_MEM_MemWrite & ~i_stall & ~i_flush & ~misaligned & i_rst_n;

        we    = '0;
        wdata = i_MEM_StoreData;
        if (i_MEM_Size[1]) begin
            we    = '1;
            wdata = i_MEM_StoreData;
        end else if (i_MEM_Size[0]) begin
            we    = lane[1] ? (HALF_LO << 2) : HALF_LO;
            wdata = {(LANES/2){i_MEM_StoreData[15:0]}};
        end else begin
            we    = LANES'(1) << lane;
            wdata = {LANES{i_MEM_StoreData[7:0]}};
        end
        if (!store_en) begin
            we = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < LANES; b++) begin
            if (we[b]) begin
                mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Raw word is kept unshifted so the RAM read port stays a plain registered read.
    always_ff @(posedge i_clk) begin
        if (!i_stall) begin
            rd_word <= mem[word_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_WB_ALU         <= '0;
            o_WB_Extend      <= '0;
            o_WB_PC8         <= '0;
            o_WB_SizeFiltroL <= '0;
            o_WB_ZeroExtend  <= 1'b0;
            o_WB_MemToReg    <= 1'b0;
            o_WB_LUI         <= 1'b0;
            o_WB_JAL         <= 1'b0;
            o_WB_RegWrite    <= 1'b0;
            o_WB_Rd          <= '0;
            o_misaligned     <= 1'b0;
            lane_q           <= '0;
            load_valid       <= 1'b0;
        end else if (i_flush) begin
            o_WB_ALU         <= '0;
            o_WB_Extend      <= '0;
            o_WB_PC8         <= '0;
            o_WB_SizeFiltroL <= '0;
            o_WB_ZeroExtend  <= 1'b0;
            o_WB_MemToReg    <= 1'b0;
            o_WB_LUI         <= 1'b0;
            o_WB_JAL         <= 1'b0;
            o_WB_RegWrite    <= 1'b0;
            o_WB_Rd          <= '0;
            o_misaligned     <= 1'b0;
            lane_q           <= '0;
            load_valid       <= 1'b0;
        end else if (!i_stall) begin
            o_WB_ALU         <= i_MEM_ALU;
            o_WB_Extend      <= i_MEM_Extend;
            o_WB_PC8         <= i_MEM_PC8;
            o_WB_SizeFiltroL <= i_MEM_Size;
            o_WB_ZeroExtend  <= i_MEM_ZeroExtend;
            o_WB_MemToReg    <= i_MEM_MemToReg;
            o_WB_LUI         <= i_MEM_LUI;
            o_WB_JAL         <= i_MEM_JAL;
            o_WB_RegWrite    <= i_MEM_RegWrite & ~misaligned;
            o_WB_Rd          <= i_MEM_Rd;
            o_misaligned     <= misaligned;
            lane_q           <= lane;
            load_valid       <= i_MEM_MemRead & ~misaligned;
        end
    end

    assign o_WB_DataMemory = load_valid ? (rd_word >> {lane_q, 3'b000}) : '0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for single-cycle behaviour,
// hand sequences for stall, flush priority, debug port and mid-stream reset.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [31:0] alu, sdata, ext, pc8;
    logic        mread, mwrite, zext, m2r, lui, jal, regw;
    logic [1:0]  size;
    logic [4:0]  rd;
    logic [7:0]  dbg_addr;

    logic [31:0] wb_data, wb_alu, wb_ext, wb_pc8, dbg_data;
    logic [1:0]  wb_size;
    logic        wb_zext, wb_m2r, wb_lui, wb_jal, wb_regw, mis;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.NBITS(32), .REGS(5), .RAM_WORDS(256)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_MEM_ALU(alu), .i_MEM_StoreData(sdata),
        .i_MEM_MemRead(mread), .i_MEM_MemWrite(mwrite), .i_MEM_Size(size),
        .i_MEM_ZeroExtend(zext), .i_MEM_MemToReg(m2r), .i_MEM_LUI(lui),
        .i_MEM_JAL(jal), .i_MEM_RegWrite(regw),
        .i_MEM_Extend(ext), .i_MEM_PC8(pc8), .i_MEM_Rd(rd),
        .o_WB_DataMemory(wb_data), .o_WB_ALU(wb_alu), .o_WB_Extend(wb_ext),
        .o_WB_PC8(wb_pc8), .o_WB_SizeFiltroL(wb_size),
        .o_WB_ZeroExtend(wb_zext), .o_WB_MemToReg(wb_m2r), .o_WB_LUI(wb_lui),
        .o_WB_JAL(wb_jal), .o_WB_RegWrite(wb_regw), .o_WB_Rd(wb_rd),
        .o_misaligned(mis), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [1:0]  size;
        logic        mread;
        logic        mwrite;
        logic        regw;
        logic [4:0]  rd;
        logic        flush;
        logic [31:0] exp_data;
        logic        exp_regw;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] sd,
                                input logic [1:0] sz, input logic r, input logic w,
                                input logic rw, input logic [4:0] d, input logic fl,
                                input logic [31:0] ed, input logic erw, input logic em);
        vec_t v;
        v.alu = a; v.sdata = sd; v.size = sz; v.mread = r; v.mwrite = w;
        v.regw = rw; v.rd = d; v.flush = fl;
        v.exp_data = ed; v.exp_regw = erw; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sz,
                         input logic r, input logic w, input logic rw, input logic [4:0] d,
                         input logic st, input logic fl);
        alu = a; sdata = sd; size = sz; mread = r; mwrite = w; regw = rw; rd = d;
        stall = st; flush = fl;
        ext = {a[15:0], 16'h0}; pc8 = a + 32'd8;
        zext = d[0]; m2r = r; lui = d[1]; jal = d[2];
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        dbg_addr = 8'd0;
        idle();

        vecs[0]  = mk(32'h00, 32'hCAFEF00D, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[1]  = mk(32'h10, 32'hDEADBEEF, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[2]  = mk(32'h04, 32'h11223344, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[3]  = mk(32'h20, 32'h0BADC0DE, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[4]  = mk(32'h30, 32'h01010101, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[5]  = mk(32'h40, 32'h13579BDF, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[6]  = mk(32'h10, 32'h0,        2'b10, 1, 0, 1, 5'd5,  0, 32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(32'h05, 32'h000000AA, 2'b00, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[8]  = mk(32'h04, 32'h0,        2'b10, 1, 0, 1, 5'd6,  0, 32'h1122AA44, 1, 0);
        vecs[9]  = mk(32'h05, 32'h0,        2'b00, 1, 0, 1, 5'd7,  0, 32'h001122AA, 1, 0);
        vecs[10] = mk(32'h06, 32'h0,        2'b01, 1, 0, 1, 5'd8,  0, 32'h00001122, 1, 0);
        vecs[11] = mk(32'h07, 32'h0,        2'b00, 1, 0, 1, 5'd9,  0, 32'h00000011, 1, 0);
        vecs[12] = mk(32'h03, 32'h00001234, 2'b01, 0, 1, 0, 5'd0,  0, 32'h0,        0, 1);
        vecs[13] = mk(32'h00, 32'h0,        2'b10, 1, 0, 1, 5'd10, 0, 32'hCAFEF00D, 1, 0);
        vecs[14] = mk(32'h02, 32'h0,        2'b10, 1, 0, 1, 5'd11, 0, 32'h0,        0, 1);
        vecs[15] = mk(32'h12, 32'hABCD5678, 2'b01, 0, 1, 0, 5'd0,  0, 32'h0,        0, 0);
        vecs[16] = mk(32'h10, 32'h0,        2'b10, 1, 0, 1, 5'd12, 0, 32'h5678BEEF, 1, 0);
        vecs[17] = mk(32'h12, 32'h0,        2'b01, 1, 0, 1, 5'd13, 0, 32'h00005678, 1, 0);
        vecs[18] = mk(32'h20, 32'h99999999, 2'b10, 0, 1, 1, 5'd7,  1, 32'h0,        0, 0);
        vecs[19] = mk(32'h20, 32'h0,        2'b10, 1, 0, 1, 5'd14, 0, 32'h0BADC0DE, 1, 0);
        vecs[20] = mk(32'h12345677, 32'h0,  2'b10, 0, 0, 1, 5'd15, 0, 32'h0,        1, 0);
        vecs[21] = mk(32'h41, 32'hFFFFFFFF, 2'b10, 0, 1, 0, 5'd0,  0, 32'h0,        0, 1);
        vecs[22] = mk(32'h40, 32'h0,        2'b10, 1, 0, 1, 5'd16, 0, 32'h13579BDF, 1, 0);
        vecs[23] = mk(32'h42, 32'h0,        2'b10, 1, 0, 1, 5'd17, 1, 32'h0,        0, 0);

        #2;
        chk("rst_data", wb_data, 32'h0);
        chk("rst_alu",  wb_alu,  32'h0);
        chk("rst_regw", {31'h0, wb_regw}, 32'h0);
        chk("rst_mis",  {31'h0, mis}, 32'h0);
        chk("rst_dbg",  dbg_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].alu, vecs[i].sdata, vecs[i].size, vecs[i].mread, vecs[i].mwrite,
                  vecs[i].regw, vecs[i].rd, 1'b0, vecs[i].flush);
            step();
            chk($sformatf("v%0d_data", i), wb_data, vecs[i].exp_data);
            chk($sformatf("v%0d_regw", i), {31'h0, wb_regw}, {31'h0, vecs[i].exp_regw});
            chk($sformatf("v%0d_mis", i),  {31'h0, mis}, {31'h0, vecs[i].exp_mis});
            chk($sformatf("v%0d_rd", i),   {27'h0, wb_rd}, vecs[i].flush ? 32'h0 : {27'h0, vecs[i].rd});
            chk($sformatf("v%0d_alu", i),  wb_alu, vecs[i].flush ? 32'h0 : vecs[i].alu);
            chk($sformatf("v%0d_ext", i),  wb_ext, vecs[i].flush ? 32'h0 : {vecs[i].alu[15:0], 16'h0});
            chk($sformatf("v%0d_pc8", i),  wb_pc8, vecs[i].flush ? 32'h0 : vecs[i].alu + 32'd8);
            chk($sformatf("v%0d_size", i), {30'h0, wb_size}, vecs[i].flush ? 32'h0 : {30'h0, vecs[i].size});
            chk($sformatf("v%0d_ctl", i),  {28'h0, wb_zext, wb_m2r, wb_lui, wb_jal},
                vecs[i].flush ? 32'h0 :
                {28'h0, vecs[i].rd[0], vecs[i].mread, vecs[i].rd[1], vecs[i].rd[2]});
        end

        // Stall: WB frozen while the load waits in MEM, then the load arrives.
        drive(32'hA5A5A5A4, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        step();
        chk("pre_stall_alu", wb_alu, 32'hA5A5A5A4);
        for (int c = 0; c < 3; c++) begin
            drive(32'h10, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
            step();
            chk($sformatf("stall%0d_alu", c), wb_alu, 32'hA5A5A5A4);
            chk($sformatf("stall%0d_rd", c), {27'h0, wb_rd}, 32'd3);
            chk($sformatf("stall%0d_data", c), wb_data, 32'h0);
        end
        drive(32'h10, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        step();
        chk("unstall_data", wb_data, 32'h5678BEEF);
        chk("unstall_rd", {27'h0, wb_rd}, 32'd9);

        // Store under stall is deferred; debug port shows old word on the write edge.
        dbg_addr = 8'd12;
        for (int c = 0; c < 2; c++) begin
            drive(32'h30, 32'h77777777, 2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
            step();
            chk($sformatf("stall_sw%0d_dbg", c), dbg_data, 32'h01010101);
        end
        drive(32'h30, 32'h77777777, 2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        chk("sw_edge_dbg_old", dbg_data, 32'h01010101);
        idle();
        step();
        chk("sw_after_dbg", dbg_data, 32'h77777777);

        // Flush wins over stall.
        drive(32'h10, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        step();
        chk("pre_flush_rd", {27'h0, wb_rd}, 32'd4);
        drive(32'h10, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1);
        step();
        chk("flush_stall_rd", {27'h0, wb_rd}, 32'h0);
        chk("flush_stall_regw", {31'h0, wb_regw}, 32'h0);
        chk("flush_stall_data", wb_data, 32'h0);

        // Reset mid-stream clears outputs at once and blocks a coincident store.
        drive(32'h10, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        step();
        chk("pre_rst_data", wb_data, 32'h5678BEEF);
        drive(32'h40, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", wb_data, 32'h0);
        chk("midrst_alu",  wb_alu,  32'h0);
        chk("midrst_rd",   {27'h0, wb_rd}, 32'h0);
        chk("midrst_regw", {31'h0, wb_regw}, 32'h0);
        chk("midrst_dbg",  dbg_data, 32'h0);
        step();
        idle();
        rst_n = 1'b1;
        dbg_addr = 8'd16;
        step();
        chk("post_rst_dbg16", dbg_data, 32'h13579BDF);
        dbg_addr = 8'd1;
        step();
        chk("post_rst_dbg1", dbg_data, 32'h1122AA44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
